// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions for the register-file write side.
//   DATA_W     : register/data width
//   ADDR_W     : register address width
//   NUM_REGS   : number of architectural registers (2**ADDR_W)
//   reg_addr_t : register address
//   word_t     : register data word
//   wb_entry_t : one pending register-file write {rd, data}
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_entry_t;

    // One-hot mask selecting a single register, used by the scoreboard.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t used to buffer load results until the
// register-file write port is free.
//   i_clk       : clock, all updates on rising edge
//   i_rst       : synchronous active-high reset (pointers and level to 0)
//   i_push      : write i_push_data (ignored while full)
//   i_push_data : entry to enqueue
//   i_pop       : remove the head entry (ignored while empty)
//   o_pop_data  : current head entry (valid while !o_empty)
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
//   o_level     : current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  wb_entry_t                i_push_data,
    input  logic                     i_pop,
    output wb_entry_t                o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic               w_push;
    logic               w_pop;

    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage carries no reset: an entry is only read once the level says
    // it has been written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
// Write-side controller for the 8 x 16-bit register file. Merges single-cycle
// ALU results and buffered load results onto the single write port, and
// keeps a pending-load scoreboard that stalls decode on hazards.
//   clock        : system clock
//   reset        : synchronous active-high reset
//   alu_valid    : ALU result this cycle (no backpressure, always wins)
//   alu_rd/data  : ALU destination and result
//   load_valid   : load result offered
//   load_ready   : load FIFO can accept
//   load_rd/data : load destination and result
//   issue_valid  : decode issued a load to issue_rd this cycle
//   chk_rs/rt/rd : decode operand/destination addresses to hazard-check
//   stall        : combinational, decode must hold
//   rf_write     : registered register-file write enable
//   rf_rd_addr   : registered write address (holds when rf_write=0)
//   rf_data      : registered write data (holds when rf_write=0)
//   lq_level     : load FIFO occupancy
//
// Load handshake: a load result transfers on a rising edge where
// load_valid && load_ready are both 1; load_ready does not depend on
// load_valid, and an offer not accepted must be held until it is.
// ---------------------------------------------------------------------------
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  reg_addr_t                  alu_rd,
    input  word_t                      alu_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  reg_addr_t                  load_rd,
    input  word_t                      load_data,
    input  logic                       issue_valid,
    input  reg_addr_t                  issue_rd,
    input  reg_addr_t                  chk_rs_addr,
    input  reg_addr_t                  chk_rt_addr,
    input  reg_addr_t                  chk_rd_addr,
    output logic                       stall,
    output logic                       rf_write,
    output reg_addr_t                  rf_rd_addr,
    output word_t                      rf_data,
    output logic [$clog2(LQ_DEPTH):0]  lq_level
);

    // Output stage
    logic                   r_rf_write;
    reg_addr_t              r_rf_rd_addr;
    word_t                  r_rf_data;
    logic                   r_src_load;

    // Scoreboard: one bit per register with an outstanding load
    logic [NUM_REGS-1:0]    r_pending;

    // FIFO interface
    wb_entry_t              w_push_entry;
    wb_entry_t              w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;

    logic [NUM_REGS-1:0]    w_set_mask;
    logic [NUM_REGS-1:0]    w_clr_mask;

    // -----------------------------------------------------------------------
    // Load FIFO
    // -----------------------------------------------------------------------
    assign load_ready   = !reset && !w_full;
    assign w_push       = load_valid && load_ready;
    assign w_push_entry = '{rd: load_rd, data: load_data};

    // The FIFO head is only drained on cycles the ALU leaves the port idle.
    assign w_pop = !alu_valid && !w_empty;

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (lq_level)
    );

    // -----------------------------------------------------------------------
    // Output stage: ALU first, then FIFO head, else idle (address/data hold)
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_write   <= 1'b0;
            r_rf_rd_addr <= '0;
            r_rf_data    <= '0;
            r_src_load   <= 1'b0;
        end else if (alu_valid) begin
            r_rf_write   <= 1'b1;
            r_rf_rd_addr <= alu_rd;
            r_rf_data    <= alu_data;
            r_src_load   <= 1'b0;
        end else if (!w_empty) begin
            r_rf_write   <= 1'b1;
            r_rf_rd_addr <= w_head.rd;
            r_rf_data    <= w_head.data;
            r_src_load   <= 1'b1;
        end else begin
            r_rf_write   <= 1'b0;
            r_src_load   <= 1'b0;
        end
    end

    assign rf_write   = r_rf_write;
    assign rf_rd_addr = r_rf_rd_addr;
    assign rf_data    = r_rf_data;

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    assign w_set_mask = issue_valid ? reg_onehot(issue_rd) : '0;

    // The clear fires on the commit edge of a load write, so the stall drops
    // only once the register file already holds the loaded value.
    assign w_clr_mask = (r_rf_write && r_src_load) ? reg_onehot(r_rf_rd_addr) : '0;

    // Applying the set after the clear makes a new issue win over a commit
    // of the same register on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign stall = !reset && (r_pending[chk_rs_addr] ||
                              r_pending[chk_rt_addr] ||
                              r_pending[chk_rd_addr]);

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
  import cpu_pkg::*;

  // clock / reset / signals
  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  load_rd;
  logic [15:0] load_data;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  chk_rs_addr;
  logic [2:0]  chk_rt_addr;
  logic [2:0]  chk_rd_addr;
  logic        stall;
  logic        rf_write;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_data;
  logic [1:0]  lq_level;

  int tests_run;
  int tests_failed;

  // scoreboard of expected writes {rd, data}
  logic [18:0] exp_q[$];

  reg_writeback #(.LQ_DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_rd     (load_rd),
    .load_data   (load_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs_addr (chk_rs_addr),
    .chk_rt_addr (chk_rt_addr),
    .chk_rd_addr (chk_rd_addr),
    .stall       (stall),
    .rf_write    (rf_write),
    .rf_rd_addr  (rf_rd_addr),
    .rf_data     (rf_data),
    .lq_level    (lq_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: a cycle begins 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    load_valid = 0; load_rd = 0; load_data = 0;
    issue_valid = 0; issue_rd = 0;
    chk_rs_addr = 0; chk_rt_addr = 0; chk_rd_addr = 0;
  endtask

  // one-cycle reset; returns at the start of the first cycle after it
  task automatic apply_reset();
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_write: got %0b expected 0", rf_write); end
      tests_run++; if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_load_ready: got %0b expected 0", load_ready); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    end
    tick();
    reset = 0;
    #1;
    tests_run++; if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_load_ready: got %0b expected 1", load_ready); end
    tests_run++; if (lq_level !== 2'd0) begin tests_failed++; $display("FAIL post_reset_lq_level: got %0d expected 0", lq_level); end
    tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL post_reset_rf_write: got %0b expected 0", rf_write); end
  endtask

  task automatic test_alu();
    apply_reset();
    alu_valid = 1; alu_rd = 3; alu_data = 16'h1234;
    tick();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    #1;
    tests_run++; if (rf_write !== 1'b1) begin tests_failed++; $display("FAIL alu_write: got %0b expected 1", rf_write); end
    tests_run++; if (rf_rd_addr !== 3'd3) begin tests_failed++; $display("FAIL alu_addr: got %0d expected 3", rf_rd_addr); end
    tests_run++; if (rf_data !== 16'h1234) begin tests_failed++; $display("FAIL alu_data: got %h expected 1234", rf_data); end
    tick();
    #1;
    tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_write: got %0b expected 0", rf_write); end
    tests_run++; if (rf_rd_addr !== 3'd3) begin tests_failed++; $display("FAIL alu_hold_addr: got %0d expected 3", rf_rd_addr); end
    tests_run++; if (rf_data !== 16'h1234) begin tests_failed++; $display("FAIL alu_hold_data: got %h expected 1234", rf_data); end
  endtask

  task automatic test_load_timing();
    apply_reset();
    chk_rs_addr = 7;
    // cycle 0
    issue_valid = 1; issue_rd = 7;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lt_stall_c0: got %0b expected 0", stall); end
    // cycles 1, 2
    for (int c = 1; c <= 2; c++) begin
      tick();
      issue_valid = 0; issue_rd = 0;
      #1;
      tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lt_stall_c%0d: got %0b expected 1", c, stall); end
    end
    // cycle 3: offer the load
    tick();
    load_valid = 1; load_rd = 7; load_data = 16'h00AB;
    #1;
    tests_run++; if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL lt_ready_c3: got %0b expected 1", load_ready); end
    // cycle 4
    tick();
    load_valid = 0; load_rd = 0; load_data = 0;
    #1;
    tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL lt_write_c4: got %0b expected 0", rf_write); end
    tests_run++; if (lq_level !== 2'd1) begin tests_failed++; $display("FAIL lt_level_c4: got %0d expected 1", lq_level); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lt_stall_c4: got %0b expected 1", stall); end
    // cycle 5: the load write
    tick();
    #1;
    tests_run++; if ({rf_write, rf_rd_addr, rf_data} !== {1'b1, 3'd7, 16'h00AB}) begin tests_failed++; $display("FAIL lt_write_c5: got %0b/%0d/%h expected 1/7/00ab", rf_write, rf_rd_addr, rf_data); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lt_stall_c5: got %0b expected 1", stall); end
    tests_run++; if (lq_level !== 2'd0) begin tests_failed++; $display("FAIL lt_level_c5: got %0d expected 0", lq_level); end
    // cycle 6
    tick();
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lt_stall_c6: got %0b expected 0", stall); end
    tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL lt_write_c6: got %0b expected 0", rf_write); end
    chk_rs_addr = 0;
  endtask

  task automatic test_contention();
    logic [18:0] exp;
    int next_load;
    apply_reset();
    exp_q.delete();
    exp_q.push_back({3'd1, 16'hA000});
    exp_q.push_back({3'd2, 16'hA001});
    exp_q.push_back({3'd3, 16'hA002});
    exp_q.push_back({3'd4, 16'hB004});
    exp_q.push_back({3'd5, 16'hB005});
    exp_q.push_back({3'd6, 16'hB006});
    next_load = 4;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      alu_valid = (c <= 2);
      alu_rd    = (c <= 2) ? 3'(c + 1) : 3'd0;
      alu_data  = (c <= 2) ? 16'(16'hA000 + c) : 16'h0;
      load_valid = (next_load <= 6);
      load_rd    = 3'(next_load);
      load_data  = 16'(16'hB000 + next_load);
      #1;
      if (c == 2 || c == 3) begin
        tests_run++; if (lq_level !== 2'd2) begin tests_failed++; $display("FAIL ct_level_c%0d: got %0d expected 2", c, lq_level); end
        tests_run++; if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL ct_ready_c%0d: got %0b expected 0", c, load_ready); end
      end
      if (c >= 1 && c <= 6) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        tests_run++; if ({rf_write, rf_rd_addr, rf_data} !== {1'b1, exp}) begin tests_failed++; $display("FAIL ct_write_c%0d: got %0b/%0d/%h expected 1/%0d/%h", c, rf_write, rf_rd_addr, rf_data, exp[18:16], exp[15:0]); end
      end else begin
        tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL ct_idle_c%0d: got %0b expected 0", c, rf_write); end
      end
      if (load_valid && load_ready) next_load++;
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ct_queue_left: got %0d expected 0", exp_q.size()); end
    drive_idle();
  endtask

  task automatic test_same_edge();
    apply_reset();
    chk_rt_addr = 2;
    // cycle 0: issue load to r2
    issue_valid = 1; issue_rd = 2;
    // cycle 1: its result arrives
    tick();
    issue_valid = 0; issue_rd = 0;
    load_valid = 1; load_rd = 2; load_data = 16'h5555;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL se_stall_c1: got %0b expected 1", stall); end
    // cycle 2: popped from FIFO
    tick();
    load_valid = 0; load_rd = 0; load_data = 0;
    // cycle 3: commit of r2 coincides with a new issue to r2
    tick();
    issue_valid = 1; issue_rd = 2;
    #1;
    tests_run++; if ({rf_write, rf_rd_addr, rf_data} !== {1'b1, 3'd2, 16'h5555}) begin tests_failed++; $display("FAIL se_write_c3: got %0b/%0d/%h expected 1/2/5555", rf_write, rf_rd_addr, rf_data); end
    for (int c = 4; c <= 6; c++) begin
      tick();
      issue_valid = 0; issue_rd = 0;
      #1;
      tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL se_stall_c%0d: got %0b expected 1", c, stall); end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    chk_rs_addr = 4;
    // cycle 0
    issue_valid = 1; issue_rd = 4;
    alu_valid = 1; alu_rd = 1; alu_data = 16'h0101;
    load_valid = 1; load_rd = 4; load_data = 16'h4444;
    // cycle 1
    tick();
    issue_valid = 0; issue_rd = 0;
    alu_rd = 2; alu_data = 16'h0202;
    load_rd = 5; load_data = 16'h5555;
    // cycle 2
    tick();
    alu_rd = 3; alu_data = 16'h0303;
    load_valid = 0; load_rd = 0; load_data = 0;
    #1;
    tests_run++; if (lq_level !== 2'd2) begin tests_failed++; $display("FAIL rm_level_before: got %0d expected 2", lq_level); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL rm_stall_before: got %0b expected 1", stall); end
    // cycle 3: reset
    tick();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    reset = 1;
    #1;
    tests_run++; if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL rm_ready_in_reset: got %0b expected 0", load_ready); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_stall_in_reset: got %0b expected 0", stall); end
    tick();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      #1;
      tests_run++; if (rf_write !== 1'b0) begin tests_failed++; $display("FAIL rm_write_after_%0d: got %0b expected 0", c, rf_write); end
      tests_run++; if (lq_level !== 2'd0) begin tests_failed++; $display("FAIL rm_level_after_%0d: got %0d expected 0", c, lq_level); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_stall_after_%0d: got %0b expected 0", c, stall); end
    end
    drive_idle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1;
    drive_idle();
    test_reset();
    test_alu();
    test_load_timing();
    test_contention();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
